i2c_tgt_regfile: RTL and testbench
==================================

// Module: i2c_tgt_regfile
// PURPOSE
// - I2C target (responder) giving an external I2C controller access to a small 8-bit register file.
// - It is the far end of the SoC i2c_if controller path; used for board bring-up and for peer-SoC links.
// - The register contents are exposed to on-chip logic.
// - A local write port allows firmware-side updates.
// PARAMETERS
// - TGT_ADDR  7'h42  7-bit target address this block acknowledges
// - NREG      8      number of 8-bit registers; power of two, 2..256
// - IW        $clog2(NREG)  index width (derived, localparam)
// PORTS
// - clk_i         in   1       system clock; SCL must be <= clk_i/16
// - rst_n_i       in   1       asynchronous reset, active-low
// - scl_i         in   1       SCL pad input
// - sda_i         in   1       SDA pad input
// - scl_o         out  1       SCL output value; constant 0
// - scl_dir_o     out  1       SCL output enable (1=drive); constant 0, no clock stretching
// - sda_o         out  1       SDA output value; constant 0 (open-drain emulation)
// - sda_dir_o     out  1       SDA output enable; 1 pulls SDA low
// - loc_wr_en_i   in   1       local write strobe
// - loc_wr_idx_i  in   IW      local write index
// - loc_wr_dat_i  in   8       local write data
// - reg_o         out  NREG*8  register file; reg n is at [8n+7:8n]
// - wr_stb_o      out  1       1-cycle pulse when an I2C write commits a byte
// - wr_idx_o      out  IW      index of that byte; valid with wr_stb_o
// - busy_o        out  1       1 from an address-matched START until STOP or NACK-exit
// BEHAVIOUR
// - Reset values: all registers 0, ptr 0, FSM IDLE, sda_dir_o 0, wr_stb_o 0, wr_idx_o 0, busy_o 0.
// - Input conditioning: scl_i/sda_i pass through a 2-flop synchroniser; edges are detected on the synced values.
// - START: SDA falls while SCL is high. It forces ADDR from any state, including repeated START.
// - STOP: SDA rises while SCL is high. It forces IDLE from any state and releases SDA.
// - Bit timing: bits are sampled on SCL rise; the target changes SDA only on SCL fall.
// - FSM states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDAT, WDAT_ACK, RDAT, RDAT_ACK, SKIP.
// - ADDR: shift 8 bits, MSB first.
//   - {addr,rw} matches TGT_ADDR: enter ADDR_ACK and set busy_o.
//   - No match: enter SKIP. SKIP ignores everything until START or STOP.
// - Any ACK state: drive sda_dir_o=1 from the SCL fall after bit 8 to the SCL fall after bit 9.
// - After ADDR_ACK: rw=0 goes to PTR; rw=1 goes to RDAT with ptr unchanged.
// - PTR byte:
//   - value < NREG: ptr <= value, ACK, enter WDAT.
//   - value >= NREG: NACK (SDA released), enter SKIP.
// - WDAT byte: at the 8th SCL rise, reg[ptr] <= byte and wr_stb_o pulses with wr_idx_o=ptr.
//   - ptr <= ptr+1, wrapping NREG-1 -> 0. ACK, then WDAT again.
// - RDAT byte:
//   - Shift register loads reg[ptr] on entry.
//   - MSB is driven on the SCL fall that ends the ACK.
//   - A 0 bit drives sda_dir_o=1; a 1 bit releases SDA.
//   - After bit 8: ptr++ with wrap, and SDA is released.
// - RDAT_ACK: sample SDA at the 9th rise. ACK(0) reloads and continues; NACK(1) enters SKIP and clears busy_o.
// - Collision: local and I2C writes commit in the same cycle to the same index: the I2C write wins, the local write is dropped.
// - Different indices in the same cycle: both commit.
// - Local write: 1-cycle latency to reg_o. No wr_stb_o pulse.
// - Reset mid-transfer: asynchronous return to reset values; SDA is released immediately.
// CONFIGURATION
// - Macro: I2C_TGT_GLITCH_FLT_EN.
// - Defined: after the synchroniser, each line passes a 3-sample filter. The filtered value changes only when 3 consecutive samples agree, which adds 2 clk of latency. Pulses narrower than 3 clk are rejected.
// - Undefined: the synchroniser only; a 1-clk glitch can be seen as an edge.
// TESTING
// - Write: START, 0x84, 0x03, 0xA5, 0x5A, STOP
//   -> reg3=0xA5, reg4=0x5A; two wr_stb_o pulses with idx 3 then 4; all ACKs low.
// - Wrap: START, 0x84, 0x07, 0x11, 0x22, STOP
//   -> reg7=0x11, reg0=0x22; final ptr=1.
// - Read with repeated START: START, 0x84, 0x06, Sr, 0x85, read 2 bytes (ACK then NACK), STOP
//   -> returns reg6, reg7; after the NACK, SDA is released and busy_o=0.
// - Address miss / bad pointer:
//   - START, 0x90 -> no ACK, no state change.
//   - START, 0x84, 0x08 -> NACK on the pointer byte; registers unchanged.
// - Collision: local write idx2=0x33 in the same cycle as I2C commit idx2=0xCC
//   -> reg2=0xCC. Local write idx5=0x77 in the same cycle -> reg5=0x77.
// - Reset: assert rst_n_i during a RDAT bit that drives 0
//   -> sda_dir_o=0 immediately; all reg_o=0.
// - Glitch: a 2-clk low pulse on SDA while SCL is high
//   - Macro defined: no START is detected.
//   - Macro undefined: the FSM enters ADDR.

Source files
------------

// File: rtl/i2c_tgt_regfile.sv
// I2C target exposing an NREG x 8-bit register file, with a local firmware write port.
// Optional 3-sample glitch filter on SCL/SDA is enabled by defining I2C_TGT_GLITCH_FLT_EN.
module i2c_tgt_regfile #(
  parameter logic [6:0] TGT_ADDR = 7'h42,
  parameter int         NREG     = 8,
  localparam int        IW       = $clog2(NREG)
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            scl_i,
  input  logic            sda_i,
  output logic            scl_o,
  output logic            scl_dir_o,
  output logic            sda_o,
  output logic            sda_dir_o,
  input  logic            loc_wr_en_i,
  input  logic [IW-1:0]   loc_wr_idx_i,
  input  logic [7:0]      loc_wr_dat_i,
  output logic [NREG*8-1:0] reg_o,
  output logic            wr_stb_o,
  output logic [IW-1:0]   wr_idx_o,
  output logic            busy_o
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDAT, WDAT_ACK, RDAT, RDAT_ACK, SKIP
  } state_t;

  state_t        state;
  logic [1:0]    scl_sync, sda_sync;
  logic          scl_f, sda_f, scl_q, sda_q;
  logic [6:0]    shreg;
  logic [3:0]    bit_cnt;
  logic [IW-1:0] ptr;
  logic          rw, ack_phase;
  logic [7:0]    regs [NREG];

  logic       scl_rise, scl_fall, start_det, stop_det, last_bit, i2c_we;
  logic [7:0] byte_in;

  assign scl_o     = 1'b0;
  assign scl_dir_o = 1'b0;
  assign sda_o     = 1'b0;

  // Synchronisers reset to the idle-bus level so reset release never looks like an edge
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
    end else begin
      scl_sync <= {scl_sync[0], scl_i};
      sda_sync <= {sda_sync[0], sda_i};
    end
  end

`ifdef I2C_TGT_GLITCH_FLT_EN
  logic [1:0] scl_hist, sda_hist;
  logic       scl_hold, sda_hold;

  // Filtered level follows the line only once three consecutive samples agree
  assign scl_f = (scl_sync[1] == scl_hist[0] && scl_hist[0] == scl_hist[1]) ? scl_sync[1] : scl_hold;
  assign sda_f = (sda_sync[1] == sda_hist[0] && sda_hist[0] == sda_hist[1]) ? sda_sync[1] : sda_hold;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      scl_hist <= 2'b11;
      sda_hist <= 2'b11;
      scl_hold <= 1'b1;
      sda_hold <= 1'b1;
    end else begin
      scl_hist <= {scl_hist[0], scl_sync[1]};
      sda_hist <= {sda_hist[0], sda_sync[1]};
      scl_hold <= scl_f;
      sda_hold <= sda_f;
    end
  end
`else
  assign scl_f = scl_sync[1];
  assign sda_f = sda_sync[1];
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      scl_q <= 1'b1;
      sda_q <= 1'b1;
    end else begin
      scl_q <= scl_f;
      sda_q <= sda_f;
    end
  end

  assign scl_rise  = scl_f & ~scl_q;
  assign scl_fall  = ~scl_f & scl_q;
  assign start_det = scl_f & scl_q & sda_q & ~sda_f;
  assign stop_det  = scl_f & scl_q & ~sda_q & sda_f;
  assign byte_in   = {shreg, sda_f};
  assign last_bit  = (bit_cnt == 4'd7);
  assign i2c_we    = (state == WDAT) && scl_rise && last_bit;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state     <= IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      ptr       <= '0;
      rw        <= 1'b0;
      ack_phase <= 1'b0;
      sda_dir_o <= 1'b0;
      wr_stb_o  <= 1'b0;
      wr_idx_o  <= '0;
      busy_o    <= 1'b0;
    end else begin
      wr_stb_o <= 1'b0;
      if (start_det) begin
        state     <= ADDR;
        bit_cnt   <= '0;
        ack_phase <= 1'b0;
        sda_dir_o <= 1'b0;
      end else if (stop_det) begin
        state     <= IDLE;
        ack_phase <= 1'b0;
        sda_dir_o <= 1'b0;
        busy_o    <= 1'b0;
      end else begin
        case (state)
          ADDR, PTR, WDAT: begin
            if (scl_rise) begin
              shreg   <= byte_in[6:0];
              bit_cnt <= bit_cnt + 4'd1;
              if (last_bit) begin
                bit_cnt <= '0;
                case (state)
                  ADDR: begin
                    if (byte_in[7:1] == TGT_ADDR) begin
                      rw     <= byte_in[0];
                      busy_o <= 1'b1;
                      state  <= ADDR_ACK;
                    end else begin
                      busy_o <= 1'b0;
                      state  <= SKIP;
                    end
                  end
                  PTR: begin
                    if (int'(byte_in) < NREG) begin
                      ptr   <= byte_in[IW-1:0];
                      state <= PTR_ACK;
                    end else begin
                      busy_o <= 1'b0;
                      state  <= SKIP;
                    end
                  end
                  default: begin
                    wr_stb_o <= 1'b1;
                    wr_idx_o <= ptr;
                    ptr      <= ptr + IW'(1);
                    state    <= WDAT_ACK;
                  end
                endcase
              end
            end
          end
          // First SCL fall pulls SDA for the ACK slot, the second one ends it
          ADDR_ACK, PTR_ACK, WDAT_ACK: begin
            if (scl_fall) begin
              if (!ack_phase) begin
                sda_dir_o <= 1'b1;
                ack_phase <= 1'b1;
              end else begin
                ack_phase <= 1'b0;
                sda_dir_o <= 1'b0;
                bit_cnt   <= '0;
                if (state == ADDR_ACK && rw) begin
                  shreg     <= regs[ptr][6:0];
                  sda_dir_o <= ~regs[ptr][7];
                  state     <= RDAT;
                end else if (state == ADDR_ACK) begin
                  state <= PTR;
                end else begin
                  state <= WDAT;
                end
              end
            end
          end
          RDAT: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt != 4'd0) begin
              if (bit_cnt == 4'd8) begin
                sda_dir_o <= 1'b0;
                ptr       <= ptr + IW'(1);
                bit_cnt   <= '0;
                state     <= RDAT_ACK;
              end else begin
                shreg     <= {shreg[5:0], 1'b0};
                sda_dir_o <= ~shreg[6];
              end
            end
          end
          RDAT_ACK: begin
            if (scl_rise) begin
              if (sda_f) begin
                busy_o <= 1'b0;
                state  <= SKIP;
              end else begin
                ack_phase <= 1'b1;
              end
            end else if (scl_fall && ack_phase) begin
              ack_phase <= 1'b0;
              shreg     <= regs[ptr][6:0];
              sda_dir_o <= ~regs[ptr][7];
              state     <= RDAT;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // I2C commit is applied last so it wins a same-index collision with the local port
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < NREG; i++) regs[i] <= 8'h00;
    end else begin
      if (loc_wr_en_i) regs[loc_wr_idx_i] <= loc_wr_dat_i;
      if (i2c_we)      regs[ptr]          <= byte_in;
    end
  end

  for (genvar g = 0; g < NREG; g++) begin : g_reg_out
    assign reg_o[8*g +: 8] = regs[g];
  end

endmodule

// File: tb/tb_i2c_tgt_regfile.sv
// Directed bench for i2c_tgt_regfile: an open-drain bus model drives I2C transactions
// and compares acks, read data, strobes and the register file against hand-computed values.
module tb_i2c_tgt_regfile;

  localparam int NREG = 8;
  localparam int IW   = 3;
  localparam int Q    = 8;
`ifdef I2C_TGT_GLITCH_FLT_EN
  localparam int LAT      = 4;
  localparam bit FLT_BUILD = 1'b1;
`else
  localparam int LAT      = 2;
  localparam bit FLT_BUILD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic scl_drv = 1'b1, sda_drv = 1'b1;
  logic scl_line, sda_line;
  logic scl_o, scl_dir_o, sda_o, sda_dir_o;
  logic loc_wr_en = 1'b0;
  logic [IW-1:0] loc_wr_idx = '0;
  logic [7:0] loc_wr_dat = '0;
  logic [NREG*8-1:0] reg_o;
  logic wr_stb_o;
  logic [IW-1:0] wr_idx_o;
  logic busy_o;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_regs [NREG];
  logic [IW-1:0] stb_q [$];
  int addr_cycles = 0;

  always #5 clk = ~clk;

  // Open-drain wired-AND of the controller and the target
  assign scl_line = scl_drv & ~(scl_dir_o & ~scl_o);
  assign sda_line = sda_drv & ~(sda_dir_o & ~sda_o);

  i2c_tgt_regfile dut (
    .clk_i(clk), .rst_n_i(rst_n), .scl_i(scl_line), .sda_i(sda_line),
    .scl_o(scl_o), .scl_dir_o(scl_dir_o), .sda_o(sda_o), .sda_dir_o(sda_dir_o),
    .loc_wr_en_i(loc_wr_en), .loc_wr_idx_i(loc_wr_idx), .loc_wr_dat_i(loc_wr_dat),
    .reg_o(reg_o), .wr_stb_o(wr_stb_o), .wr_idx_o(wr_idx_o), .busy_o(busy_o)
  );

  always @(negedge clk) begin
    if (wr_stb_o) stb_q.push_back(wr_idx_o);
    if (int'(dut.state) == 1) addr_cycles++;
  end

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NREG*8-1:0] exp_vec();
    logic [NREG*8-1:0] v;
    for (int i = 0; i < NREG; i++) v[8*i +: 8] = exp_regs[i];
    return v;
  endfunction

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_drv = 1'b1; wait_q();
    scl_drv = 1'b1; wait_q();
    sda_drv = 1'b0; wait_q();
    scl_drv = 1'b0; wait_q();
  endtask

  task automatic i2c_stop();
    sda_drv = 1'b0; wait_q();
    scl_drv = 1'b1; wait_q();
    sda_drv = 1'b1; wait_q();
    wait_q();
  endtask

  // Optionally lands a local write in the same clock as the I2C commit of the last bit
  task automatic write_byte(input logic [7:0] b, input bit lw, input logic [IW-1:0] lidx,
                            input logic [7:0] ldat, output logic ack);
    for (int i = 7; i >= 0; i--) begin
      sda_drv = b[i]; wait_q();
      scl_drv = 1'b1;
      if (lw && i == 0) begin
        repeat (LAT) @(negedge clk);
        loc_wr_idx = lidx; loc_wr_dat = ldat; loc_wr_en = 1'b1;
        @(negedge clk);
        loc_wr_en = 1'b0;
        repeat (2*Q - LAT - 1) @(negedge clk);
      end else begin
        wait_q(); wait_q();
      end
      scl_drv = 1'b0; wait_q();
    end
    sda_drv = 1'b1; wait_q();
    scl_drv = 1'b1; wait_q();
    ack = sda_line; wait_q();
    scl_drv = 1'b0; wait_q();
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      sda_drv = 1'b1; wait_q();
      scl_drv = 1'b1; wait_q();
      b[i] = sda_line; wait_q();
      scl_drv = 1'b0; wait_q();
    end
    sda_drv = nack; wait_q();
    scl_drv = 1'b1; wait_q(); wait_q();
    scl_drv = 1'b0; wait_q();
    sda_drv = 1'b1;
  endtask

  task automatic local_write(input logic [IW-1:0] idx, input logic [7:0] dat);
    loc_wr_idx = idx; loc_wr_dat = dat; loc_wr_en = 1'b1;
    @(negedge clk);
    loc_wr_en = 1'b0;
  endtask

  initial begin
    logic ack;
    logic [7:0] rd;
    int n0, a0;

    for (int i = 0; i < NREG; i++) exp_regs[i] = 8'h00;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_regs", reg_o, '0);
    check("rst_sda_dir", sda_dir_o, 1'b0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_wr_stb", wr_stb_o, 1'b0);
    check("rst_wr_idx", wr_idx_o, '0);
    check("scl_dir", scl_dir_o, 1'b0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Write two bytes from pointer 3
    n0 = stb_q.size();
    i2c_start();
    write_byte(8'h84, 0, '0, '0, ack); check("wr_ack_addr", ack, 1'b0);
    write_byte(8'h03, 0, '0, '0, ack); check("wr_ack_ptr", ack, 1'b0);
    check("wr_busy", busy_o, 1'b1);
    write_byte(8'hA5, 0, '0, '0, ack); check("wr_ack_d0", ack, 1'b0);
    write_byte(8'h5A, 0, '0, '0, ack); check("wr_ack_d1", ack, 1'b0);
    i2c_stop();
    check("wr_busy_stop", busy_o, 1'b0);
    exp_regs[3] = 8'hA5; exp_regs[4] = 8'h5A;
    check("wr_regs", reg_o, exp_vec());
    check("wr_stb_count", stb_q.size() - n0, 2);
    if (stb_q.size() >= n0 + 2) begin
      check("wr_stb_idx0", stb_q[n0], 3'd3);
      check("wr_stb_idx1", stb_q[n0+1], 3'd4);
    end

    // Pointer wrap 7 -> 0
    i2c_start();
    write_byte(8'h84, 0, '0, '0, ack);
    write_byte(8'h07, 0, '0, '0, ack);
    write_byte(8'h11, 0, '0, '0, ack);
    write_byte(8'h22, 0, '0, '0, ack); check("wrap_ack", ack, 1'b0);
    i2c_stop();
    exp_regs[7] = 8'h11; exp_regs[0] = 8'h22;
    check("wrap_regs", reg_o, exp_vec());

    // Local writes: one-cycle latency and no strobe
    n0 = stb_q.size();
    local_write(3'd1, 8'h3C); exp_regs[1] = 8'h3C;
    check("loc_latency", reg_o, exp_vec());
    local_write(3'd6, 8'h6C); exp_regs[6] = 8'h6C;
    check("loc_regs", reg_o, exp_vec());
    check("loc_no_stb", stb_q.size() - n0, 0);

    // Read without setting the pointer returns reg1 (ptr left at 1 by the wrap)
    i2c_start();
    write_byte(8'h85, 0, '0, '0, ack); check("rd_ack_addr", ack, 1'b0);
    read_byte(1'b1, rd); check("rd_ptr1", rd, 8'h3C);
    i2c_stop();

    // Pointer set then repeated START read of two bytes
    i2c_start();
    write_byte(8'h84, 0, '0, '0, ack);
    write_byte(8'h06, 0, '0, '0, ack);
    i2c_start();
    write_byte(8'h85, 0, '0, '0, ack); check("sr_ack_addr", ack, 1'b0);
    read_byte(1'b0, rd); check("sr_rd0", rd, 8'h6C);
    read_byte(1'b1, rd); check("sr_rd1", rd, 8'h11);
    check("sr_sda_rel", sda_dir_o, 1'b0);
    check("sr_busy", busy_o, 1'b0);
    i2c_stop();

    // Address miss
    i2c_start();
    write_byte(8'h90, 0, '0, '0, ack); check("miss_nack", ack, 1'b1);
    check("miss_busy", busy_o, 1'b0);
    i2c_stop();
    check("miss_regs", reg_o, exp_vec());

    // Pointer out of range
    i2c_start();
    write_byte(8'h84, 0, '0, '0, ack);
    write_byte(8'h08, 0, '0, '0, ack); check("badptr_nack", ack, 1'b1);
    write_byte(8'hEE, 0, '0, '0, ack);
    i2c_stop();
    check("badptr_regs", reg_o, exp_vec());

    // Collisions with the local port
    i2c_start();
    write_byte(8'h84, 0, '0, '0, ack);
    write_byte(8'h02, 0, '0, '0, ack);
    write_byte(8'hCC, 1, 3'd2, 8'h33, ack);
    write_byte(8'hDD, 1, 3'd5, 8'h77, ack);
    i2c_stop();
    exp_regs[2] = 8'hCC; exp_regs[3] = 8'hDD; exp_regs[5] = 8'h77;
    check("coll_regs", reg_o, exp_vec());

    // Reset while the target drives a 0 data bit (reg4 = 0x5A, ptr = 4)
    i2c_start();
    write_byte(8'h85, 0, '0, '0, ack);
    check("rdat_drive0", sda_dir_o, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_sda", sda_dir_o, 1'b0);
    check("rst_mid_regs", reg_o, '0);
    check("rst_mid_busy", busy_o, 1'b0);
    for (int i = 0; i < NREG; i++) exp_regs[i] = 8'h00;
    sda_drv = 1'b1; scl_drv = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);

    // Two-clock low glitch on SDA with SCL high
    a0 = addr_cycles;
    sda_drv = 1'b0;
    repeat (2) @(negedge clk);
    sda_drv = 1'b1;
    repeat (12) @(negedge clk);
    check("glitch_start", (addr_cycles > a0) ? 1'b1 : 1'b0, FLT_BUILD ? 1'b0 : 1'b1);
    check("glitch_busy", busy_o, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
